mbox_rx_if: RTL and testbench

- Wishbone slave that drains the inbound byte MAILBOX (host→FPGA direction) and reassembles 32-bit words, LSB first.
- It is the receive-side counterpart of the outbound MAILBOX serializer in the SFIFO interface.
- A 4-byte assembly shift register feeds a 1-word hold register (double-buffered), so one word can be read while the next is being collected.
- Sits on the wb_clk_i (clk_500) domain, beside the SFIFO interface, on the same Wishbone slave bus.

---
 rtl/mbox_pkg.sv | 22 ++
 rtl/mbox_rx_if_if.sv | 25 ++
 rtl/mbox_rx_asm.sv | 80 ++++++++
 rtl/mbox_rx_if.sv | 124 ++++++++++++
 tb/tb_mbox_rx_if.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbox_pkg.sv
// Shared constants for the inbound mailbox word reassembler: register offsets,
// CTRL bit positions and the assembly state derived from the byte count.
package mbox_pkg;
    localparam int MBOX_BYTES = 4;

    localparam logic [2:0] MBOX_IBUF = 3'h0;
    localparam logic [2:0] MBOX_STAT = 3'h1;
    localparam logic [2:0] MBOX_CTRL = 3'h2;

    localparam int CTRL_FLUSH_BIT   = 24;
    localparam int CTRL_IRQ_EN_BIT  = 25;
    localparam int CTRL_CLR_OVR_BIT = 26;

    typedef enum logic {
        ASM_FILL  = 1'b0,
        ASM_STALL = 1'b1
    } asm_state_e;

    function automatic asm_state_e asm_state(input logic [2:0] cnt);
        return (cnt == 3'(MBOX_BYTES)) ? ASM_STALL : ASM_FILL;
    endfunction
endpackage

// File: rtl/mbox_rx_if_if.sv
// Wishbone slave bus bundle for the inbound mailbox reader; the slave modport
// is the register block, the master modport is the bus host.
interface mbox_rx_if_if #(
    parameter int WB_AW = 5,
    parameter int WB_DW = 32
);
    logic                 wb_cyc_i;
    logic                 wb_stb_i;
    logic                 wb_we_i;
    logic [3:0]           wb_sel_i;
    logic [WB_AW-3:0]     wb_adr_i;
    logic [WB_DW-1:0]     wb_dat_i;
    logic [WB_DW-1:0]     wb_dat_o;
    logic                 wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/mbox_rx_asm.sv
// Byte-to-word assembler with a one-word hold buffer; pops the mailbox in the same
// cycle it sees a byte, and stalls the mailbox while a full word waits for the hold.
module mbox_rx_asm
    import mbox_pkg::*;
#(
    parameter int WOU_DW = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mbox_empty_i,
    input  logic [WOU_DW-1:0]            mbox_di_i,
    output logic                         mbox_rd_o,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic                         hold_valid_o,
    output logic [MBOX_BYTES*WOU_DW-1:0] hold_buf_o,
    output logic [2:0]                   asm_cnt_o,
    output logic                         ovr_set_o
);
    localparam int WW = MBOX_BYTES * WOU_DW;

    logic [2:0]    asm_cnt_q, asm_cnt_d;
    logic [WW-1:0] asm_buf_q, asm_buf_d;
    logic [WW-1:0] hold_buf_q, hold_buf_d;
    logic          hold_valid_q, hold_valid_d;
    asm_state_e    state;
    logic          xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_cnt_q    <= '0;
            asm_buf_q    <= '0;
            hold_buf_q   <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            asm_cnt_q    <= asm_cnt_d;
            asm_buf_q    <= asm_buf_d;
            hold_buf_q   <= hold_buf_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Gated by rst so the mailbox is never popped while the byte would be discarded.
    always_comb begin
        state     = asm_state(asm_cnt_q);
        mbox_rd_o = ~rst & ~mbox_empty_i & (state == ASM_FILL) & ~flush_i;
        xfer      = (state == ASM_STALL) & (~hold_valid_q | pop_i);
        ovr_set_o = mbox_rd_o & (asm_cnt_q == 3'(MBOX_BYTES - 1)) & hold_valid_q & ~pop_i;
    end

    always_comb begin
        asm_cnt_d    = asm_cnt_q;
        asm_buf_d    = asm_buf_q;
        hold_buf_d   = hold_buf_q;
        hold_valid_d = hold_valid_q;
        if (flush_i) begin
            asm_cnt_d    = '0;
            hold_valid_d = 1'b0;
        end else begin
            if (xfer) begin
                hold_buf_d   = asm_buf_q;
                hold_valid_d = 1'b1;
                asm_cnt_d    = '0;
            end else if (pop_i) begin
                hold_valid_d = 1'b0;
            end
            // Never coincides with xfer: a full assembler blocks mbox_rd_o.
            if (mbox_rd_o) begin
                asm_cnt_d = asm_cnt_q + 3'd1;
                for (int i = 0; i < MBOX_BYTES; i++) begin
                    if (int'(asm_cnt_q) == i) asm_buf_d[i*WOU_DW +: WOU_DW] = mbox_di_i;
                end
            end
        end
    end

    assign hold_valid_o = hold_valid_q;
    assign hold_buf_o   = hold_buf_q;
    assign asm_cnt_o    = asm_cnt_q;
endmodule

// File: rtl/mbox_rx_if.sv
// Wishbone register front end of the inbound mailbox reader; 1-cycle ack, IBUF reads
// withhold ack until a word is held. irq_o exists only when MBOX_RX_IRQ_EN is defined.
module mbox_rx_if
    import mbox_pkg::*;
#(
    parameter int WB_AW  = 5,
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    mbox_rx_if_if.slave       wb,
    output logic              mbox_rd_o,
    input  logic [WOU_DW-1:0] mbox_di_i,
    input  logic              mbox_empty_i
`ifdef MBOX_RX_IRQ_EN
    ,
    output logic              irq_o
`endif
);
    localparam int ADR_W = WB_AW - 2;

    logic             ack_q, ack_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic             overrun_q, overrun_d;
    logic             irq_en;
    logic             req, rd_req, wr_req;
    logic             ibuf_sel, stat_sel, ctrl_sel, ctrl_wr;
    logic             pop_now, flush_now, ovr_set, ovr_clr;
    logic             hold_valid;
    logic [WB_DW-1:0] hold_buf;
    logic [2:0]       asm_cnt;
    logic [WB_DW-1:0] stat_word, ctrl_word;
    logic             unused_ok;

    mbox_rx_asm #(.WOU_DW(WOU_DW)) u_asm (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .mbox_empty_i (mbox_empty_i),
        .mbox_di_i    (mbox_di_i),
        .mbox_rd_o    (mbox_rd_o),
        .pop_i        (pop_now),
        .flush_i      (flush_now),
        .hold_valid_o (hold_valid),
        .hold_buf_o   (hold_buf),
        .asm_cnt_o    (asm_cnt),
        .ovr_set_o    (ovr_set)
    );

    // Decode is qualified by ~ack_q so a strobe held through its ack acts only once.
    always_comb begin
        req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        rd_req    = req & ~wb.wb_we_i;
        wr_req    = req & wb.wb_we_i;
        ibuf_sel  = (wb.wb_adr_i == ADR_W'(MBOX_IBUF));
        stat_sel  = (wb.wb_adr_i == ADR_W'(MBOX_STAT));
        ctrl_sel  = (wb.wb_adr_i == ADR_W'(MBOX_CTRL));
        ctrl_wr   = wr_req & ctrl_sel & wb.wb_sel_i[3];
        flush_now = ctrl_wr & wb.wb_dat_i[CTRL_FLUSH_BIT];
        ovr_clr   = ctrl_wr & wb.wb_dat_i[CTRL_CLR_OVR_BIT];
        pop_now   = rd_req & ibuf_sel & hold_valid;
        ack_d     = req & ~(ibuf_sel & ~wb.wb_we_i & ~hold_valid);

        stat_word    = '0;
        stat_word[0] = hold_valid;
        stat_word[3:1] = asm_cnt;
        stat_word[4] = overrun_q;
        ctrl_word    = '0;
        ctrl_word[CTRL_IRQ_EN_BIT] = irq_en;

        dat_d = dat_q;
        if (rd_req & ack_d) begin
            if (ibuf_sel)      dat_d = hold_buf;
            else if (stat_sel) dat_d = stat_word;
            else if (ctrl_sel) dat_d = ctrl_word;
            else               dat_d = '0;
        end

        overrun_d = overrun_q;
        if (ovr_clr)      overrun_d = 1'b0;
        else if (ovr_set) overrun_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef MBOX_RX_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) irq_en_d = wb.wb_dat_i[CTRL_IRQ_EN_BIT];
        irq_d = irq_en_q & hold_valid;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
`else
    assign irq_en = 1'b0;
`endif

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign unused_ok   = &{1'b0, wb.wb_sel_i[2:0], wb.wb_dat_i};
endmodule

// File: tb/tb_mbox_rx_if.sv
// Directed bench for mbox_rx_if: a vector table for single register accesses plus
// hand sequences for empty-read wait, overrun stall, async reset and (MBOX_RX_IRQ_EN) irq.
module tb_mbox_rx_if;
    import mbox_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mbox_rx_if_if #(.WB_AW(5), .WB_DW(32)) wb ();
    logic       mbox_rd_o;
    logic [7:0] mbox_di_i;
    logic       mbox_empty_i;
`ifdef MBOX_RX_IRQ_EN
    logic       irq_o;
    localparam logic [31:0] IRQ_RB = 32'h0200_0000;
`else
    localparam logic [31:0] IRQ_RB = 32'h0000_0000;
`endif

    mbox_rx_if #(.WB_AW(5), .WB_DW(32), .WOU_DW(8)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wb           (wb),
        .mbox_rd_o    (mbox_rd_o),
        .mbox_di_i    (mbox_di_i),
        .mbox_empty_i (mbox_empty_i)
`ifdef MBOX_RX_IRQ_EN
        ,
        .irq_o        (irq_o)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] q[$];

    // First-word-fall-through mailbox: inputs settle after negedge, pop on the posedge.
    initial begin
        mbox_empty_i = 1'b1;
        mbox_di_i    = 8'h00;
    end
    always begin
        @(negedge clk);
        #1;
        mbox_empty_i = (q.size() == 0);
        mbox_di_i    = (q.size() != 0) ? q[0] : 8'h00;
        #3;
        if (mbox_rd_o) begin
            @(posedge clk);
            if (q.size() != 0) void'(q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [2:0] adr, input logic [31:0] wdat,
                             input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_sel_i = sel;  wb.wb_adr_i = adr;  wb.wb_dat_i = wdat;
        lat = 0; rdat = 'x;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (wb.wb_ack_o) begin
                lat = i; rdat = wb.wb_dat_o;
                break;
            end
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        if (lat == 0) begin
            n_vec++; n_bad++;
            $display("FAIL ack_timeout: adr %h got no ack, expected one", adr);
        end
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [31:0] rdat, output int lat);
        wb_access(1'b0, adr, 32'h0, 4'hf, rdat, lat);
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [31:0] wdat, input logic [3:0] sel,
                            output int lat);
        logic [31:0] dummy;
        wb_access(1'b1, adr, wdat, sel, dummy, lat);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d bytes left, expected 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    typedef enum {V_PUSH, V_DRAIN, V_RD, V_WR} vop_e;
    typedef struct {
        vop_e        op;
        logic [2:0]  adr;
        logic [31:0] dat;   // push byte, write data or expected read data
        logic [3:0]  sel;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(vop_e op, logic [2:0] adr, logic [31:0] dat, logic [3:0] sel);
        vec_t v;
        v.op = op; v.adr = adr; v.dat = dat; v.sel = sel;
        return v;
    endfunction

    logic [31:0] rd;
    int          lat;
    int          acks;
    int          k;

    initial begin
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_sel_i = 4'h0; wb.wb_adr_i = 3'h0; wb.wb_dat_i = 32'h0;

        tbl.push_back(mk(V_RD,    MBOX_STAT, 32'h0000_0000, 4'hf));
        tbl.push_back(mk(V_RD,    MBOX_CTRL, 32'h0000_0000, 4'hf));
        tbl.push_back(mk(V_RD,    3'h3,      32'h0000_0000, 4'hf));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'h11, 4'h0));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'h22, 4'h0));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'h33, 4'h0));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'h44, 4'h0));
        tbl.push_back(mk(V_DRAIN, 3'h0,      32'h0,  4'h0));
        tbl.push_back(mk(V_RD,    MBOX_STAT, 32'h0000_0001, 4'hf));
        tbl.push_back(mk(V_RD,    MBOX_IBUF, 32'h4433_2211, 4'hf));
        tbl.push_back(mk(V_RD,    MBOX_STAT, 32'h0000_0000, 4'hf));
        tbl.push_back(mk(V_WR,    3'h5,      32'hffff_ffff, 4'hf));
        tbl.push_back(mk(V_RD,    3'h5,      32'h0000_0000, 4'hf));
        tbl.push_back(mk(V_WR,    MBOX_IBUF, 32'hdead_beef, 4'hf));
        tbl.push_back(mk(V_RD,    MBOX_STAT, 32'h0000_0000, 4'hf));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'he1, 4'h0));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'he2, 4'h0));
        tbl.push_back(mk(V_DRAIN, 3'h0,      32'h0,  4'h0));
        tbl.push_back(mk(V_RD,    MBOX_STAT, 32'h0000_0004, 4'hf));
        tbl.push_back(mk(V_WR,    MBOX_CTRL, 32'h0100_0000, 4'h7));
        tbl.push_back(mk(V_RD,    MBOX_STAT, 32'h0000_0004, 4'hf));
        tbl.push_back(mk(V_WR,    MBOX_CTRL, 32'h0100_0000, 4'h8));
        tbl.push_back(mk(V_RD,    MBOX_STAT, 32'h0000_0000, 4'hf));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'h01, 4'h0));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'h02, 4'h0));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'h03, 4'h0));
        tbl.push_back(mk(V_PUSH,  3'h0,      32'h04, 4'h0));
        tbl.push_back(mk(V_DRAIN, 3'h0,      32'h0,  4'h0));
        tbl.push_back(mk(V_RD,    MBOX_IBUF, 32'h0403_0201, 4'hf));
        tbl.push_back(mk(V_WR,    MBOX_CTRL, 32'h0200_0000, 4'hf));
        tbl.push_back(mk(V_RD,    MBOX_CTRL, IRQ_RB,        4'hf));

        repeat (3) @(negedge clk);
        check("reset_ack", {31'd0, wb.wb_ack_o}, 32'h0);
        check("reset_dat", wb.wb_dat_o, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                V_PUSH:  q.push_back(tbl[i].dat[7:0]);
                V_DRAIN: drain();
                V_RD: begin
                    wb_read(tbl[i].adr, rd, lat);
                    check($sformatf("vec%0d_rdata", i), rd, tbl[i].dat);
                    check($sformatf("vec%0d_rlat", i), lat, 32'd1);
                end
                V_WR: begin
                    wb_write(tbl[i].adr, tbl[i].dat, tbl[i].sel, lat);
                    check($sformatf("vec%0d_wlat", i), lat, 32'd1);
                end
                default: ;
            endcase
        end

        // IBUF read issued on an empty mailbox must stall until a word assembles.
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_sel_i = 4'hf; wb.wb_adr_i = MBOX_IBUF;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb.wb_ack_o) acks++;
        end
        check("empty_rd_noack", acks, 32'd0);
        q.push_back(8'hAA); q.push_back(8'hBB); q.push_back(8'hCC); q.push_back(8'hDD);
        lat = 0; rd = 'x;
        for (int i = 21; i <= 100; i++) begin
            @(negedge clk);
            if (wb.wb_ack_o) begin
                lat = i; rd = wb.wb_dat_o;
                break;
            end
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        check("empty_rd_data", rd, 32'hDDCC_BBAA);
        check("empty_rd_late", {31'd0, lat > 20}, 32'd1);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb.wb_ack_o) acks++;
        end
        check("empty_rd_one_ack", acks, 32'd0);

        // Twelve bytes, no reads: two words absorbed, mailbox stalled, overrun flagged.
        @(negedge clk);
        for (int i = 0; i < 12; i++) q.push_back(8'(i));
        repeat (40) @(negedge clk);
        check("ovr_left_in_fifo", q.size(), 32'd4);
        check("ovr_rd_stalled", {31'd0, mbox_rd_o}, 32'd0);
        wb_read(MBOX_STAT, rd, lat);
        check("ovr_stat", rd, 32'h0000_0019);
        wb_read(MBOX_IBUF, rd, lat);
        check("ovr_word0", rd, 32'h0302_0100);
        check("ovr_word0_lat", lat, 32'd1);
        wb_read(MBOX_IBUF, rd, lat);
        check("ovr_word1", rd, 32'h0706_0504);
        wb_read(MBOX_IBUF, rd, lat);
        check("ovr_word2", rd, 32'h0B0A_0908);
        wb_read(MBOX_STAT, rd, lat);
        check("ovr_sticky", rd, 32'h0000_0010);
        wb_write(MBOX_CTRL, 32'h0400_0000, 4'h8, lat);
        wb_read(MBOX_STAT, rd, lat);
        check("ovr_cleared", rd, 32'h0000_0000);

        // Asynchronous reset with a partial word pending.
        q.push_back(8'h91); q.push_back(8'h92); q.push_back(8'h93);
        drain();
        wb_read(MBOX_STAT, rd, lat);
        check("rst_pre_stat", rd, 32'h0000_0006);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
        check("rst_dat", wb.wb_dat_o, 32'h0);
        check("rst_rd", {31'd0, mbox_rd_o}, 32'd0);
`ifdef MBOX_RX_IRQ_EN
        check("rst_irq", {31'd0, irq_o}, 32'd0);
`endif
        q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3); q.push_back(8'hA4);
        repeat (3) @(negedge clk);
        #2;
        check("rst_rd_gated", {31'd0, mbox_rd_o}, 32'd0);
        check("rst_fifo_kept", q.size(), 32'd4);
        @(negedge clk);
        rst = 1'b0;
        drain();
        wb_read(MBOX_IBUF, rd, lat);
        check("rst_fresh_word", rd, 32'hA4A3_A2A1);
        wb_read(MBOX_STAT, rd, lat);
        check("rst_post_stat", rd, 32'h0000_0000);

`ifdef MBOX_RX_IRQ_EN
        wb_write(MBOX_CTRL, 32'h0200_0000, 4'h8, lat);
        @(negedge clk);
        q.push_back(8'h5A); q.push_back(8'h6B); q.push_back(8'h7C); q.push_back(8'h8D);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (irq_o) begin
                k = i;
                break;
            end
        end
        check("irq_rise_cycle", k, 32'd6);
        wb_read(MBOX_IBUF, rd, lat);
        check("irq_word", rd, 32'h8D7C_6B5A);
        check("irq_at_ack", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'd0, irq_o}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
